// File: rtl/fsm_pkg.sv
// Shared types for the lab5 fsm and its command-sequence generator.
// Holds the control_signal symbol type, the generator state type and the default idle symbol.
package fsm_pkg;

    typedef enum logic [1:0] {
        a = 2'b00,
        b = 2'b01,
        c = 2'b10
    } ctrl_sym_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    localparam ctrl_sym_t DEFAULT_IDLE_SYM = a;

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_cmd_mem.sv
// Pattern storage for fsm_cmd_gen: DEPTH symbols, synchronous write, combinational read.
// Every entry returns to IDLE_SYM on reset so an unloaded pattern plays as idle symbols.
module fsm_cmd_mem
    import fsm_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter ctrl_sym_t   IDLE_SYM = DEFAULT_IDLE_SYM
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  ctrl_sym_t                wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output ctrl_sym_t                rd_data_o
);

    ctrl_sym_t mem_q [DEPTH];

    // NOTE: the array is deliberately reset (it is tiny); a RAM macro could not be,
    // which is why this lives in flops rather than an inferred memory.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= IDLE_SYM;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fsm_cmd_gen.sv
// Programmable command-sequence transmitter driving control_signal of the lab5 fsm.
// Plays a stored pattern of symbols once or looped, each held for REPEAT cycles.
module fsm_cmd_gen
    import fsm_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned REPEAT   = 1,
    parameter ctrl_sym_t   IDLE_SYM = DEFAULT_IDLE_SYM
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  ctrl_sym_t                wr_data_i,
    input  logic [$clog2(DEPTH):0]   len_i,
    input  logic                     loop_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    output ctrl_sym_t                control_signal,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   RW       = cnt_width(REPEAT);
    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT - 1);

    gen_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q,   ptr_d;
    logic [RW-1:0] rpt_q,   rpt_d;
    logic [AW:0]   len_q,   len_d;
    logic          loop_q,  loop_d;

    ctrl_sym_t     ctrl_q,  ctrl_d;
    logic          valid_q, valid_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    ctrl_sym_t     rd_sym;
    logic [AW:0]   len_clamped;
    logic [AW:0]   last_idx;
    logic          last_slot;
    logic          last_entry;
    logic          wr_ok;

    // The pattern is frozen while playing so a running sequence never changes under us.
    assign wr_ok = wr_en_i && (state_q != PLAY);

    fsm_cmd_mem #(
        .DEPTH    (DEPTH),
        .IDLE_SYM (IDLE_SYM)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (ptr_q),
        .rd_data_o (rd_sym)
    );

    assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign last_idx    = len_q - (AW+1)'(1);
    assign last_slot   = (rpt_q == RPT_LAST);
    assign last_entry  = ({1'b0, ptr_q} == last_idx);

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; without that, synthesis would infer latches.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rpt_d   = rpt_q;
        len_d   = len_q;
        loop_d  = loop_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = PLAY;
                        len_d   = len_clamped;
                        loop_d  = loop_i;
                        ptr_d   = '0;
                        rpt_d   = '0;
                    end
                end
            end
            PLAY: begin
                if (stop_i) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    rpt_d   = '0;
                end else if (last_slot) begin
                    rpt_d = '0;
                    if (last_entry) begin
                        if (loop_q) begin
                            ptr_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end else begin
                    rpt_d = rpt_q + RW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are a registered image of the current state, one cycle behind it.
    always_comb begin
        ctrl_d  = IDLE_SYM;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_q == PLAY) begin
            ctrl_d  = rd_sym;
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end
        if (state_q == DONE) begin
            done_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rpt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            ctrl_q  <= IDLE_SYM;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rpt_q   <= rpt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign control_signal = ctrl_q;
    assign valid_o        = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_fsm_cmd_gen.sv
// Self-checking bench for fsm_cmd_gen: REPEAT=1 and REPEAT=2 instances share stimulus
// and are compared every cycle against a timeline model of the playback schedule.
`timescale 1ns/1ps
module tb_fsm_cmd_gen;
    import fsm_pkg::*;

    localparam int DEPTH = 8;
    localparam int NI    = 2;
    localparam ctrl_sym_t TB_IDLE = a;

    logic       clk_i;
    logic       rst_i;
    logic       wr_en_i;
    logic [2:0] wr_addr_i;
    ctrl_sym_t  wr_data_i;
    logic [3:0] len_i;
    logic       loop_i;
    logic       start_i;
    logic       stop_i;

    ctrl_sym_t  ctrl_o  [NI];
    logic       valid_o [NI];
    logic       busy_o  [NI];
    logic       done_o  [NI];

    fsm_cmd_gen #(.DEPTH(DEPTH), .REPEAT(1), .IDLE_SYM(a)) u_dut_r1 (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .len_i(len_i), .loop_i(loop_i), .start_i(start_i),
        .stop_i(stop_i), .control_signal(ctrl_o[0]), .valid_o(valid_o[0]),
        .busy_o(busy_o[0]), .done_o(done_o[0])
    );

    fsm_cmd_gen #(.DEPTH(DEPTH), .REPEAT(2), .IDLE_SYM(a)) u_dut_r2 (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .len_i(len_i), .loop_i(loop_i), .start_i(start_i),
        .stop_i(stop_i), .control_signal(ctrl_o[1]), .valid_o(valid_o[1]),
        .busy_o(busy_o[1]), .done_o(done_o[1])
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: per instance, the stored pattern and the most recent accepted
    // start (edge, length, loop) plus the edge a stop cut it short (-1 if none).
    ctrl_sym_t m_mem    [NI][DEPTH];
    bit        m_active [NI];
    bit        m_loop   [NI];
    int        m_n      [NI];
    int        m_len    [NI];
    int        m_stop   [NI];
    int        cyc;
    int        checks;
    int        failures;

    ctrl_sym_t pat [6] = '{b, a, c, b, a, b};

    function automatic int rep_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // True when the generator was playing just before edge e (so the cycle after e shows a symbol).
    function automatic bit in_play(input int i, input int e);
        if (!m_active[i] || m_len[i] == 0 || e < m_n[i] + 1) return 1'b0;
        if (m_stop[i] >= 0 && e > m_stop[i]) return 1'b0;
        if (m_loop[i]) return 1'b1;
        return e <= m_n[i] + m_len[i] * rep_of(i);
    endfunction

    function automatic bit in_done(input int i, input int e);
        if (!m_active[i] || m_stop[i] >= 0) return 1'b0;
        if (m_len[i] == 0) return e == m_n[i] + 1;
        if (m_loop[i]) return 1'b0;
        return e == m_n[i] + m_len[i] * rep_of(i) + 1;
    endfunction

    function automatic ctrl_sym_t exp_sym(input int i, input int e);
        if (!in_play(i, e)) return TB_IDLE;
        return m_mem[i][((e - m_n[i] - 1) / rep_of(i)) % m_len[i]];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NI; i++) begin
            m_active[i] = 1'b0;
            m_loop[i]   = 1'b0;
            m_n[i]      = 0;
            m_len[i]    = 0;
            m_stop[i]   = -1;
            for (int k = 0; k < DEPTH; k++) m_mem[i][k] = TB_IDLE;
        end
    endtask

    task automatic apply_events(input int i, input int e);
        bit play;
        bit idle;
        play = in_play(i, e);
        idle = !play && !in_done(i, e);
        if (wr_en_i && !play) m_mem[i][wr_addr_i] = wr_data_i;
        if (start_i && idle) begin
            m_active[i] = 1'b1;
            m_n[i]      = e;
            m_len[i]    = (int'(len_i) > DEPTH) ? DEPTH : int'(len_i);
            m_loop[i]   = loop_i;
            m_stop[i]   = -1;
        end else if (stop_i && play) begin
            m_stop[i] = e;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge: predict outputs for the cycle after it, fold in the events
    // sampled at it, compare, then drop single-cycle pulses.
    task automatic tick();
        ctrl_sym_t e_sym  [NI];
        bit        e_play [NI];
        bit        e_done [NI];
        @(posedge clk_i);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            e_sym[i]  = exp_sym(i, cyc);
            e_play[i] = in_play(i, cyc);
            e_done[i] = in_done(i, cyc);
        end
        if (rst_i) begin
            for (int i = 0; i < NI; i++) apply_events(i, cyc);
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("r%0d_ctrl", rep_of(i)),  ctrl_o[i],  e_sym[i]);
            check($sformatf("r%0d_valid", rep_of(i)), valid_o[i], e_play[i]);
            check($sformatf("r%0d_busy", rep_of(i)),  busy_o[i],  e_play[i]);
            check($sformatf("r%0d_done", rep_of(i)),  done_o[i],  e_done[i]);
        end
        wr_en_i = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write_sym(input int addr, input ctrl_sym_t sym);
        wr_en_i   = 1'b1;
        wr_addr_i = 3'(addr);
        wr_data_i = sym;
        tick();
    endtask

    task automatic start_play(input int len, input bit lp);
        start_i = 1'b1;
        len_i   = 4'(len);
        loop_i  = lp;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_i     = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = a;
        len_i     = '0;
        loop_i    = 1'b0;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        reset_model();

        // Reset state, then release.
        run(3);
        rst_i = 1'b1;
        run(2);

        // Load b,a,c,b,a,b and play it once.
        for (int k = 0; k < 6; k++) write_sym(k, pat[k]);
        start_play(6, 0);
        run(16);

        // Looped first three entries, stopped five cycles after start.
        start_play(3, 1);
        run(4);
        stop_i = 1'b1;
        tick();
        run(4);

        // Longer loop to cover several wraps at both repeat rates.
        start_play(3, 1);
        run(14);
        stop_i = 1'b1;
        tick();
        run(3);

        // Zero-length start: a lone done pulse.
        start_play(0, 0);
        run(3);

        // A second start during playback is ignored.
        start_play(6, 0);
        run(2);
        start_i = 1'b1;
        len_i   = 4'd2;
        loop_i  = 1'b1;
        tick();
        run(14);

        // Write during playback is dropped; after done it lands and replay shows it.
        start_play(6, 0);
        run(2);
        write_sym(1, c);
        run(14);
        write_sym(1, c);
        start_play(6, 0);
        run(15);

        // Write and start in the same idle cycle: playback sees the new value.
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd0;
        wr_data_i = a;
        start_play(2, 0);
        run(7);

        // Length above DEPTH is clamped.
        start_play(12, 0);
        run(20);

        // Randomized writes, lengths, loop modes, stops and gaps.
        repeat (25) begin
            repeat ($urandom_range(0, 2)) begin
                write_sym(int'($urandom_range(0, 7)), ctrl_sym_t'(2'($urandom_range(0, 2))));
            end
            start_play(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            run(int'($urandom_range(1, 20)));
            if ($urandom_range(0, 1) == 1) begin
                stop_i = 1'b1;
                tick();
            end
            run(int'($urandom_range(0, 4)));
        end
        stop_i = 1'b1;
        tick();
        run(2);

        // Asynchronous reset in the middle of a looped playback.
        for (int k = 0; k < DEPTH; k++) write_sym(k, (k % 2 == 0) ? c : b);
        start_play(8, 1);
        run(3);
        #2;
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("r%0d_async_ctrl", rep_of(i)),  ctrl_o[i],  TB_IDLE);
            check($sformatf("r%0d_async_valid", rep_of(i)), valid_o[i], 1'b0);
            check($sformatf("r%0d_async_busy", rep_of(i)),  busy_o[i],  1'b0);
            check($sformatf("r%0d_async_done", rep_of(i)),  done_o[i],  1'b0);
        end
        reset_model();
        run(2);
        rst_i = 1'b1;
        run(2);

        // Memory came back as all idle symbols.
        start_play(8, 0);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_cmd_gen.md
# fsm_cmd_gen

Programmable command-sequence transmitter that drives the 2-bit `control_signal` input of the lab5 `fsm` block. It stores a short pattern of symbols (`a`, `b`, `c`) written through a simple write port. On `start_i` it plays the pattern out one symbol per slot, either once or looped. It is the driving end of the `control_signal` interface and replaces hand-written stimulus in system-level runs.

## Interface
Parameters:
- `DEPTH`, 8: pattern storage entries; power of two, at least 2.
- `REPEAT`, 1: clock cycles each symbol is held on the output; at least 1.
- `IDLE_SYM`, `a`: symbol driven whenever no pattern is playing.

Ports:
- `clk_i`, in, 1: clock; everything is on the rising edge.
- `rst_i`, in, 1: reset. Asynchronous, active-low.
- `wr_en_i`, in, 1: write pattern entry.
- `wr_addr_i`, in, $clog2(DEPTH): entry index.
- `wr_data_i`, in, 2: symbol to store (package symbol type).
- `len_i`, in, $clog2(DEPTH)+1: number of entries to play, 0..DEPTH; sampled at start.
- `loop_i`, in, 1: replay from entry 0 after the last entry; sampled at start.
- `start_i`, in, 1: begin playback; only accepted in IDLE.
- `stop_i`, in, 1: abort playback.
- `control_signal`, out, 2: current symbol, registered.
- `valid_o`, out, 1: high while `control_signal` carries a pattern symbol.
- `busy_o`, out, 1: high in PLAY.
- `done_o`, out, 1: one-cycle pulse at the end of playback.

## Operation
- States (package enum `gen_state_t`): IDLE, PLAY, DONE.
- IDLE:
  - `control_signal` = `IDLE_SYM`; `valid_o`, `busy_o` and `done_o` are all 0.
  - `start_i` with `len_i` > 0: latch `len_i` and `loop_i`, clear the pointer and repeat counter, go to PLAY.
  - `start_i` with `len_i` = 0: go to DONE; no symbols are emitted.
- PLAY:
  - Output is `mem[ptr]` with `valid_o` = 1.
  - The repeat counter counts 0..REPEAT-1; at REPEAT-1 the pointer advances.
  - At `ptr` = `len`-1 with the counter at REPEAT-1:
    - `loop` = 1: `ptr` wraps to 0 and playback continues.
    - `loop` = 0: go to DONE.
- DONE: lasts exactly one cycle. `done_o` = 1, output returns to `IDLE_SYM`, `valid_o` = 0, `busy_o` = 0. Then IDLE.
- `stop_i` in PLAY goes to IDLE directly, with no `done_o`. It takes priority over a simultaneous advance or wrap.
- `start_i` while in PLAY or DONE is ignored.
- Writes:
  - Accepted only in IDLE and DONE. `wr_en_i` during PLAY is dropped, so the pattern cannot change mid-playback.
  - A write and `start_i` in the same IDLE cycle: the write lands, and playback reads the new value.
- `len_i` > DEPTH is clamped to DEPTH.
- Reset, including mid-playback: state IDLE, all memory entries set to `IDLE_SYM`, `control_signal` = `IDLE_SYM`, `valid_o`, `busy_o` and `done_o` all 0, counters 0.

## Timing
- `start_i` is sampled at edge N. The first symbol appears after edge N+1 and is stable for REPEAT cycles.
- Entry k of a non-looped pattern is valid during cycles N+1+k·REPEAT through N+(k+1)·REPEAT.
- `done_o` is high during cycle N+1+len·REPEAT.
- With `len_i` = 0, `done_o` is high during cycle N+1.
- Looped patterns run back to back, with no gap cycle at the wrap.
- `stop_i` sampled at edge M: the output is `IDLE_SYM` with `valid_o` = 0 from cycle M+1.
- All outputs are registered, with no combinational path from any input to any output.
- Outputs change at the rising edge. The `fsm` samples `control_signal` on its own rising edge, so the symbol it sees is the one held for that cycle.

## Structure
- Shared package `fsm_pkg`:
  - The existing symbol type with `a`, `b`, `c`.
  - New `gen_state_t`.
  - Default `IDLE_SYM`.
- Sub-module `fsm_cmd_mem`:
  - DEPTH×2 register array, asynchronous active-low reset to `IDLE_SYM`.
  - Synchronous write port; combinational read port addressed by `ptr`.
- Top level holds the state register, pointer, repeat counter, length/loop latches and the output registers.

## Test plan
- Reset, REPEAT=1, load `b,a,c,b,a,b`, `len_i`=6, `loop_i`=0, pulse start: `control_signal` = b,a,c,b,a,b on cycles 1–6 with `valid_o`=1; `done_o` pulses on cycle 7; output `a` from then on.
- Same pattern, `loop_i`=1, `len_i`=3: b,a,c,b,a,c,… with no gap, and `done_o` never fires. `stop_i` at cycle 5 gives `IDLE_SYM` with `valid_o`=0 on cycle 6 and no `done_o`.
- REPEAT=2 instance, pattern `c,b`, `len_i`=2: output c,c,b,b, then `done_o` on cycle 5.
- `len_i`=0 start: `done_o` on cycle 1, `valid_o` never asserts. A second `start_i` asserted during PLAY is ignored and the sequence completes unchanged.
- During PLAY, write entry 1 = `c` (previously `a`): the played sequence still shows `a`. After `done_o`, the write succeeds and a replay shows `c`.
- `rst_i` low asynchronously mid-PLAY: all outputs are at reset values before the next edge, and the memory reads back all `IDLE_SYM`.
